// File: rtl/sched_if.sv
// Scheduler <-> ID stage bundle: requests from ID, pipeline controls and interrupt state back.
interface sched_if;
  logic        schi_pause_request;
  logic [3:0]  schi_sched_type;
  logic [3:0]  schi_sched_count;
  logic [15:0] schi_instr_addr;
  logic        schi_int;
  logic [3:0]  schi_int_id;
  logic        schi_int_en_value;
  logic        schi_int_en_strobe;
  logic        schi_hw_int;
  logic [3:0]  schi_hw_int_id;

  logic        scho_stall_pc;
  logic        scho_stall_if_id;
  logic        scho_flush_if_id;
  logic        scho_flush_id_ex;
  logic        scho_pc_redirect;
  logic [15:0] scho_new_pc;
  logic        scho_int_en;
  logic [7:0]  scho_cause;
  logic [15:0] scho_epc;

  // ID stage side: issues requests, observes controls and interrupt state
  modport master (
    output schi_pause_request, schi_sched_type, schi_sched_count, schi_instr_addr,
           schi_int, schi_int_id, schi_int_en_value, schi_int_en_strobe,
           schi_hw_int, schi_hw_int_id,
    input  scho_stall_pc, scho_stall_if_id, scho_flush_if_id, scho_flush_id_ex,
           scho_pc_redirect, scho_new_pc, scho_int_en, scho_cause, scho_epc
  );

  // Scheduler side
  modport slave (
    input  schi_pause_request, schi_sched_type, schi_sched_count, schi_instr_addr,
           schi_int, schi_int_id, schi_int_en_value, schi_int_en_strobe,
           schi_hw_int, schi_hw_int_id,
    output scho_stall_pc, scho_stall_if_id, scho_flush_if_id, scho_flush_id_ex,
           scho_pc_redirect, scho_new_pc, scho_int_en, scho_cause, scho_epc
  );
endinterface

// File: rtl/sched.sv
// Pipeline scheduler: turns ID stall/interrupt requests into stall, flush and PC redirect,
// and owns the interrupt state (enable, cause, EPC).
module sched #(
  parameter logic [15:0] INT_VECTOR = 16'h0008
) (
  input  logic  clk,
  input  logic  rst,
  sched_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned PC_W  = 16;
  localparam int unsigned CAU_W = 8;

  localparam logic [3:0] SCHED_CONTINUE = 4'h0;
  localparam logic [3:0] ERET_ID        = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               int_en_q, int_en_d;
  logic [CAU_W-1:0]   cause_q, cause_d;
  logic [PC_W-1:0]    epc_q, epc_d;

  logic               accept_c;
  logic               stall_req_c;
  logic               sw_int_c;
  logic               eret_c;
  logic               hw_take_c;
  logic               strobe_c;

  logic               stall_c;
  logic               redirect_c;
  logic [PC_W-1:0]    new_pc_c;

  // Request decode in priority order; HOLDOFF behaves like RUN except hardware interrupts wait
  always_comb begin
    accept_c    = (state_q != ST_STALL);
    stall_req_c = accept_c && bus.schi_pause_request &&
                  (bus.schi_sched_type != SCHED_CONTINUE);
    sw_int_c    = accept_c && !stall_req_c && bus.schi_int &&
                  (bus.schi_int_id != ERET_ID);
    eret_c      = accept_c && !stall_req_c && bus.schi_int &&
                  (bus.schi_int_id == ERET_ID);
    hw_take_c   = (state_q == ST_RUN) && !stall_req_c && !bus.schi_int &&
                  bus.schi_hw_int && int_en_q;
    strobe_c    = accept_c && !stall_req_c && !bus.schi_int && !hw_take_c &&
                  bus.schi_int_en_strobe;
  end

  // State and interrupt-state register, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      int_en_q <= 1'b0;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      int_en_q <= int_en_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  // Next-state and interrupt-state update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    int_en_d = int_en_q;
    cause_d  = cause_q;
    epc_d    = epc_q;

    unique case (state_q)
      ST_STALL: begin
        // Counter holds the stall cycles left including this one
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end

      ST_RUN, ST_HOLDOFF: begin
        state_d = ST_RUN;
        if (stall_req_c) begin
          // Count 0 or 1 means a single stall cycle, which is this one
          if (bus.schi_sched_count > CNT_W'(1)) begin
            state_d = ST_STALL;
            cnt_d   = bus.schi_sched_count - CNT_W'(1);
          end
        end else if (sw_int_c) begin
          epc_d    = bus.schi_instr_addr + PC_W'(1);
          cause_d  = {4'h0, bus.schi_int_id};
          int_en_d = 1'b0;
          state_d  = ST_HOLDOFF;
        end else if (eret_c) begin
          int_en_d = 1'b1;
          state_d  = ST_HOLDOFF;
        end else if (hw_take_c) begin
          // The ID instruction is squashed, so it is the one to return to
          epc_d    = bus.schi_instr_addr;
          cause_d  = {4'h8, bus.schi_hw_int_id};
          int_en_d = 1'b0;
          state_d  = ST_HOLDOFF;
        end else if (strobe_c) begin
          int_en_d = bus.schi_int_en_value;
        end
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Pipeline controls, combinational from state and current requests
  always_comb begin
    stall_c    = 1'b0;
    redirect_c = 1'b0;
    new_pc_c   = '0;

    if (state_q == ST_STALL || stall_req_c) begin
      stall_c = 1'b1;
    end else if (sw_int_c || hw_take_c) begin
      redirect_c = 1'b1;
      new_pc_c   = INT_VECTOR;
    end else if (eret_c) begin
      redirect_c = 1'b1;
      new_pc_c   = epc_q;
    end
  end

  assign bus.scho_stall_pc    = stall_c;
  assign bus.scho_stall_if_id = stall_c;
  assign bus.scho_flush_id_ex = stall_c | redirect_c;
  assign bus.scho_flush_if_id = redirect_c;
  assign bus.scho_pc_redirect = redirect_c;
  assign bus.scho_new_pc      = new_pc_c;
  assign bus.scho_int_en      = int_en_q;
  assign bus.scho_cause       = cause_q;
  assign bus.scho_epc         = epc_q;

endmodule

// File: tb/tb_sched.sv
// Self-checking bench for sched: directed scenarios plus randomized traffic against a cycle model.
module tb_sched;

  logic clk;
  logic rst;
  sched_if bus();

  sched #(.INT_VECTOR(16'h0008)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;

  // Reference model: stall cycles still owed, holdoff flag, interrupt state
  int          m_left;
  bit          m_holdoff;
  logic        m_int_en;
  logic [7:0]  m_cause;
  logic [15:0] m_epc;

  function automatic logic [45:0] obs_vec();
    return {bus.scho_stall_pc, bus.scho_stall_if_id, bus.scho_flush_if_id,
            bus.scho_flush_id_ex, bus.scho_pc_redirect, bus.scho_new_pc,
            bus.scho_int_en, bus.scho_cause, bus.scho_epc};
  endfunction

  // Expected outputs this cycle from the model and the current requests
  function automatic logic [45:0] exp_vec();
    logic st, rd;
    logic [15:0] pc;
    st = 1'b0; rd = 1'b0; pc = 16'h0000;
    if (m_left > 0) st = 1'b1;
    else if (bus.schi_pause_request && bus.schi_sched_type != 4'h0) st = 1'b1;
    else if (bus.schi_int) begin
      rd = 1'b1;
      pc = (bus.schi_int_id == 4'hF) ? m_epc : 16'h0008;
    end else if (bus.schi_hw_int && m_int_en && !m_holdoff) begin
      rd = 1'b1;
      pc = 16'h0008;
    end
    return {st, st, rd, st | rd, rd, pc, m_int_en, m_cause, m_epc};
  endfunction

  // Advance one clock: compute the model's next state from current inputs, then commit at the edge
  task automatic adv();
    int          n_left;
    bit          n_hold;
    logic        n_en;
    logic [7:0]  n_cause;
    logic [15:0] n_epc;
    n_left = 0; n_hold = 0; n_en = m_int_en; n_cause = m_cause; n_epc = m_epc;
    if (rst) begin
      n_en = 1'b0; n_cause = 8'h00; n_epc = 16'h0000;
    end else if (m_left > 0) begin
      n_left = m_left - 1;
    end else if (bus.schi_pause_request && bus.schi_sched_type != 4'h0) begin
      n_left = (bus.schi_sched_count == 0) ? 0 : int'(bus.schi_sched_count) - 1;
    end else if (bus.schi_int && bus.schi_int_id != 4'hF) begin
      n_epc = bus.schi_instr_addr + 16'd1;
      n_cause = {4'h0, bus.schi_int_id};
      n_en = 1'b0; n_hold = 1;
    end else if (bus.schi_int) begin
      n_en = 1'b1; n_hold = 1;
    end else if (bus.schi_hw_int && m_int_en && !m_holdoff) begin
      n_epc = bus.schi_instr_addr;
      n_cause = {4'h8, bus.schi_hw_int_id};
      n_en = 1'b0; n_hold = 1;
    end else if (bus.schi_int_en_strobe) begin
      n_en = bus.schi_int_en_value;
    end
    @(posedge clk);
    m_left = n_left; m_holdoff = n_hold; m_int_en = n_en; m_cause = n_cause; m_epc = n_epc;
    #1;
  endtask

  task automatic idle();
    bus.schi_pause_request = 1'b0;
    bus.schi_sched_type    = 4'h0;
    bus.schi_sched_count   = 4'h0;
    bus.schi_instr_addr    = 16'h0000;
    bus.schi_int           = 1'b0;
    bus.schi_int_id        = 4'h0;
    bus.schi_int_en_value  = 1'b0;
    bus.schi_int_en_strobe = 1'b0;
    bus.schi_hw_int        = 1'b0;
    bus.schi_hw_int_id     = 4'h0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    adv();
    adv();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_vec() !== 46'h0) $display("FAIL reset_state got=%h exp=%h", obs_vec(), 46'h0);
    else n_pass++;
    adv();
  endtask

  task automatic test_lw_hazard();
    idle();
    bus.schi_pause_request = 1'b1;
    bus.schi_sched_type    = 4'h1;
    bus.schi_sched_count   = 4'h0;
    @(negedge clk);
    n_checks++;
    if ({bus.scho_stall_pc, bus.scho_stall_if_id, bus.scho_flush_id_ex, bus.scho_pc_redirect} !== 4'b1110)
      $display("FAIL lw_stall got=%b exp=1110",
               {bus.scho_stall_pc, bus.scho_stall_if_id, bus.scho_flush_id_ex, bus.scho_pc_redirect});
    else n_pass++;
    adv();
    idle();
    @(negedge clk);
    n_checks++;
    if ({bus.scho_stall_pc, bus.scho_stall_if_id, bus.scho_flush_id_ex} !== 3'b000)
      $display("FAIL lw_release got=%b exp=000",
               {bus.scho_stall_pc, bus.scho_stall_if_id, bus.scho_flush_id_ex});
    else n_pass++;
    adv();
  endtask

  task automatic test_multi_stall();
    logic en_before;
    en_before = m_int_en;
    idle();
    bus.schi_pause_request = 1'b1;
    bus.schi_sched_type    = 4'h2;
    bus.schi_sched_count   = 4'h3;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.scho_stall_pc !== (c < 3) || bus.scho_stall_if_id !== (c < 3) ||
          bus.scho_flush_id_ex !== (c < 3) || bus.scho_pc_redirect !== 1'b0)
        $display("FAIL multi_stall_cycle%0d stall=%b redir=%b exp_stall=%b", c,
                 bus.scho_stall_pc, bus.scho_pc_redirect, (c < 3));
      else n_pass++;
      adv();
      // Inputs keep changing during the stall, including a strobe and an INT
      idle();
      if (c == 0) begin
        bus.schi_int_en_strobe = 1'b1;
        bus.schi_int_en_value  = ~en_before;
        bus.schi_int           = 1'b1;
        bus.schi_int_id        = 4'h3;
      end else if (c == 1) begin
        bus.schi_int_en_strobe = 1'b1;
        bus.schi_int_en_value  = ~en_before;
        bus.schi_instr_addr    = 16'h1234;
      end
    end
    n_checks++;
    if (bus.scho_int_en !== en_before)
      $display("FAIL strobe_in_stall int_en=%b exp=%b", bus.scho_int_en, en_before);
    else n_pass++;
    idle();
  endtask

  task automatic test_sw_int();
    idle();
    bus.schi_int        = 1'b1;
    bus.schi_int_id     = 4'h5;
    bus.schi_instr_addr = 16'h0040;
    @(negedge clk);
    n_checks++;
    if ({bus.scho_pc_redirect, bus.scho_flush_if_id, bus.scho_flush_id_ex, bus.scho_stall_pc} !== 4'b1110 ||
        bus.scho_new_pc !== 16'h0008)
      $display("FAIL sw_int_redirect ctl=%b pc=%h exp ctl=1110 pc=0008",
               {bus.scho_pc_redirect, bus.scho_flush_if_id, bus.scho_flush_id_ex, bus.scho_stall_pc},
               bus.scho_new_pc);
    else n_pass++;
    adv();
    idle();
    @(negedge clk);
    n_checks++;
    if (bus.scho_epc !== 16'h0041 || bus.scho_cause !== 8'h05 || bus.scho_int_en !== 1'b0)
      $display("FAIL sw_int_state epc=%h cause=%h en=%b exp 0041 05 0",
               bus.scho_epc, bus.scho_cause, bus.scho_int_en);
    else n_pass++;
    adv();
    bus.schi_int    = 1'b1;
    bus.schi_int_id = 4'hF;
    @(negedge clk);
    n_checks++;
    if (bus.scho_pc_redirect !== 1'b1 || bus.scho_new_pc !== 16'h0041 || bus.scho_flush_if_id !== 1'b1)
      $display("FAIL eret_redirect redir=%b pc=%h exp 1 0041", bus.scho_pc_redirect, bus.scho_new_pc);
    else n_pass++;
    adv();
    idle();
    @(negedge clk);
    n_checks++;
    if (bus.scho_int_en !== 1'b1 || bus.scho_pc_redirect !== 1'b0)
      $display("FAIL eret_state en=%b redir=%b exp 1 0", bus.scho_int_en, bus.scho_pc_redirect);
    else n_pass++;
    adv();
  endtask

  task automatic test_hw_int();
    idle();
    bus.schi_hw_int     = 1'b1;
    bus.schi_hw_int_id  = 4'h2;
    bus.schi_instr_addr = 16'h0100;
    @(negedge clk);
    n_checks++;
    if (bus.scho_pc_redirect !== 1'b1 || bus.scho_new_pc !== 16'h0008 ||
        bus.scho_flush_if_id !== 1'b1 || bus.scho_flush_id_ex !== 1'b1)
      $display("FAIL hw_redirect redir=%b pc=%h exp 1 0008", bus.scho_pc_redirect, bus.scho_new_pc);
    else n_pass++;
    adv();
    // Level still high during HOLDOFF
    bus.schi_instr_addr = 16'h0008;
    @(negedge clk);
    n_checks++;
    if (bus.scho_pc_redirect !== 1'b0 || bus.scho_epc !== 16'h0100 ||
        bus.scho_cause !== 8'h82 || bus.scho_int_en !== 1'b0)
      $display("FAIL hw_holdoff redir=%b epc=%h cause=%h en=%b exp 0 0100 82 0",
               bus.scho_pc_redirect, bus.scho_epc, bus.scho_cause, bus.scho_int_en);
    else n_pass++;
    adv();
    idle();
    adv();
  endtask

  task automatic test_masking();
    idle();
    bus.schi_hw_int    = 1'b1;
    bus.schi_hw_int_id = 4'h7;
    bus.schi_instr_addr = 16'h0200;
    @(negedge clk);
    n_checks++;
    if (bus.scho_pc_redirect !== 1'b0 || bus.scho_int_en !== 1'b0)
      $display("FAIL masked_hw redir=%b en=%b exp 0 0", bus.scho_pc_redirect, bus.scho_int_en);
    else n_pass++;
    adv();
    bus.schi_int_en_strobe = 1'b1;
    bus.schi_int_en_value  = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.scho_pc_redirect !== 1'b0)
      $display("FAIL masked_hw_strobe_cycle redir=%b exp 0", bus.scho_pc_redirect);
    else n_pass++;
    adv();
    bus.schi_int_en_strobe = 1'b0;
    bus.schi_instr_addr    = 16'h0201;
    @(negedge clk);
    n_checks++;
    if (bus.scho_int_en !== 1'b1 || bus.scho_pc_redirect !== 1'b1 || bus.scho_new_pc !== 16'h0008)
      $display("FAIL unmasked_hw en=%b redir=%b pc=%h exp 1 1 0008",
               bus.scho_int_en, bus.scho_pc_redirect, bus.scho_new_pc);
    else n_pass++;
    adv();
    idle();
    @(negedge clk);
    n_checks++;
    if (bus.scho_epc !== 16'h0201 || bus.scho_cause !== 8'h87)
      $display("FAIL unmasked_hw_state epc=%h cause=%h exp 0201 87", bus.scho_epc, bus.scho_cause);
    else n_pass++;
    adv();
  endtask

  task automatic test_epc_wrap();
    idle();
    bus.schi_int        = 1'b1;
    bus.schi_int_id     = 4'hA;
    bus.schi_instr_addr = 16'hFFFF;
    adv();
    idle();
    @(negedge clk);
    n_checks++;
    if (bus.scho_epc !== 16'h0000 || bus.scho_cause !== 8'h0A)
      $display("FAIL epc_wrap epc=%h cause=%h exp 0000 0a", bus.scho_epc, bus.scho_cause);
    else n_pass++;
    adv();
  endtask

  task automatic test_reset_mid_stall();
    idle();
    // Enable interrupts first so reset has something to clear
    bus.schi_int_en_strobe = 1'b1;
    bus.schi_int_en_value  = 1'b1;
    adv();
    idle();
    bus.schi_pause_request = 1'b1;
    bus.schi_sched_type    = 4'h1;
    bus.schi_sched_count   = 4'h3;
    adv();
    idle();
    rst = 1'b1;
    adv();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_vec() !== 46'h0) $display("FAIL reset_mid_stall got=%h exp=%h", obs_vec(), 46'h0);
    else n_pass++;
    bus.schi_pause_request = 1'b1;
    bus.schi_sched_type    = 4'h1;
    bus.schi_sched_count   = 4'h1;
    @(negedge clk);
    n_checks++;
    if (bus.scho_stall_pc !== 1'b1 || bus.scho_flush_id_ex !== 1'b1)
      $display("FAIL pause_after_reset stall=%b flush=%b exp 1 1", bus.scho_stall_pc, bus.scho_flush_id_ex);
    else n_pass++;
    adv();
    idle();
    @(negedge clk);
    n_checks++;
    if (bus.scho_stall_pc !== 1'b0)
      $display("FAIL pause_after_reset_release stall=%b exp 0", bus.scho_stall_pc);
    else n_pass++;
    adv();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      bus.schi_pause_request = ($urandom_range(0, 99) < 15);
      bus.schi_sched_type    = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      bus.schi_sched_count   = 4'($urandom_range(0, 5));
      bus.schi_instr_addr    = 16'($urandom);
      bus.schi_int           = ($urandom_range(0, 99) < 12);
      bus.schi_int_id        = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      bus.schi_int_en_value  = 1'($urandom_range(0, 1));
      bus.schi_int_en_strobe = ($urandom_range(0, 99) < 20);
      bus.schi_hw_int        = ($urandom_range(0, 99) < 40);
      bus.schi_hw_int_id     = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (!rst) begin
        n_checks++;
        if (obs_vec() !== exp_vec())
          $display("FAIL random_cycle%0d got=%h exp=%h", i, obs_vec(), exp_vec());
        else n_pass++;
      end
      adv();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    m_left    = 0;
    m_holdoff = 0;
    m_int_en  = 1'b0;
    m_cause   = 8'h00;
    m_epc     = 16'h0000;
    rst       = 1'b1;
    idle();
    test_reset();
    test_lw_hazard();
    test_multi_stall();
    test_sw_int();
    test_hw_int();
    test_masking();
    test_epc_wrap();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sched.md
Name: sched

Overview:
- Pipeline scheduler. It consumes the ID stage's schedule, interrupt and interrupt-enable requests and issues the matching actions: stall, flush and PC redirect.
- Owns the interrupt state: int-enable bit, cause, EPC.
- Feeds that state back to ID, to be read by MFIH and tested by MTIH.
- Also accepts one external hardware interrupt line.

Parameters:
- INT_VECTOR, 16'h0008, PC loaded on any interrupt entry (software INT or hardware).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- schi_pause_request  in  1  ID requests a stall this cycle
- schi_sched_type  in  4  ID schedule code (SCHED_CONTINUE, SCHED_PAUSE_FOR_LW, ...)
- schi_sched_count  in  4  requested stall length in cycles; 0 is treated as 1
- schi_instr_addr  in  16  PC of the instruction currently in ID
- schi_int  in  1  software INT decoded in ID
- schi_int_id  in  4  INT number; 4'hF means ERET
- schi_int_en_value  in  1  new int-enable value from MTIH
- schi_int_en_strobe  in  1  one-cycle strobe; apply schi_int_en_value
- schi_hw_int  in  1  external interrupt request, level
- schi_hw_int_id  in  4  external interrupt number
- scho_stall_pc  out  1  hold PC
- scho_stall_if_id  out  1  hold IF/ID register
- scho_flush_if_id  out  1  load NOP into IF/ID
- scho_flush_id_ex  out  1  load bubble into ID/EX
- scho_pc_redirect  out  1  PC takes scho_new_pc next edge
- scho_new_pc  out  16  redirect target
- scho_int_en  out  1  interrupt enable bit (to idi_sched_int_en)
- scho_cause  out  8  last interrupt cause (to idi_cause)
- scho_epc  out  16  saved return address

Behaviour:
- Reset:
  - state=RUN, stall counter=0.
  - scho_int_en=0, scho_cause=8'h00, scho_epc=16'h0000.
  - All stall, flush and redirect outputs are 0; scho_new_pc=0.
- States: RUN, STALL, HOLDOFF.
- Stall, flush and redirect outputs are combinational from the state and the current inputs. Registers update on the clk edge.

RUN priority, highest first:
1. Stall request:
   - Condition: schi_pause_request=1 and schi_sched_type != SCHED_CONTINUE.
   - Assert scho_stall_pc, scho_stall_if_id and scho_flush_id_ex this cycle.
   - If schi_sched_count>1: counter<=count-1, go to STALL. Otherwise stay in RUN.
   - Any schi_int or schi_int_en_strobe in the same cycle is ignored; ID re-presents the instruction.
2. Software INT (schi_int=1, id != 4'hF):
   - Assert redirect with scho_new_pc=INT_VECTOR, plus flush_if_id and flush_id_ex.
   - Edge: epc<=schi_instr_addr+1, cause<={4'h0,id}, int_en<=0, go to HOLDOFF.
3. ERET (schi_int=1, id=4'hF):
   - Assert redirect with scho_new_pc=scho_epc, plus flush_if_id and flush_id_ex.
   - Edge: int_en<=1, go to HOLDOFF.
4. Hardware interrupt (schi_hw_int=1 and scho_int_en=1):
   - Same outputs as a software INT.
   - Edge: epc<=schi_instr_addr (the ID instruction is squashed and re-executed), cause<={4'h8,hw_id}, int_en<=0, go to HOLDOFF.
5. schi_int_en_strobe=1 (only when none of 1–4 applies): int_en<=schi_int_en_value next edge.

STALL:
- Assert scho_stall_pc, scho_stall_if_id and scho_flush_id_ex.
- Ignore all other inputs.
- Decrement the counter each cycle. When the counter reaches 1, return to RUN after this cycle.
- Example: count=3 gives 3 stall cycles total.

HOLDOFF:
- Lasts exactly one cycle, then RUN.
- Hardware interrupts are not accepted here. The int_en strobe and software INT are processed as in RUN.
- Purpose: guarantees the handler's or return target's first instruction reaches ID.

Boundary conditions:
- Address arithmetic is 16-bit and wraps: epc=16'hFFFF+1 gives 16'h0000.
- A hardware interrupt level held while int_en=0 is not lost. It is taken on the first RUN cycle after int_en becomes 1 (ERET or MTIH), honouring HOLDOFF.
- Reset mid-STALL or mid-HOLDOFF returns everything to reset values on the next edge.

Test Plan:
- LW hazard: pause_request=1, type=SCHED_PAUSE_FOR_LW, count=0 for one cycle → stall_pc, stall_if_id and flush_id_ex high for exactly 1 cycle; state stays RUN.
- Multi-cycle stall: pause_request=1, count=3 → stall outputs high for 3 consecutive cycles while the inputs change; deasserted in cycle 4.
- INT 5 at schi_instr_addr=16'h0040 → redirect=1, new_pc=16'h0008, both flushes; next cycle epc=16'h0041, cause=8'h05, int_en=0. Then INT 4'hF → new_pc=16'h0041, int_en=1 afterward.
- Hardware interrupt: int_en=1, hw_int=1, hw_id=2, instr_addr=16'h0100 → new_pc=16'h0008, epc=16'h0100, cause=8'h82. hw_int held high through the following HOLDOFF → no second redirect.
- Masking: int_en=0, hw_int=1 → no redirect. MTIH strobe value=1 → int_en=1 next cycle, interrupt taken the cycle after. A strobe during a stall cycle → int_en unchanged.
- Reset in STALL with counter=2 → all outputs 0 and int_en=0 after the edge; a new pause_request is accepted immediately.
